cgra_io_stream_responder: RTL

// - CGRA-side endpoint for one PRR column, the far end of the GLB tile's g2f/f2g stream and config ports.
// - Responds to GLB config writes and reads through a small register file.
// - Accepts g2f words (io16 vld/rdy plus io1 ctrl) into a FIFO, adds an optional offset, and returns them as f2g.
// - Used as the synthesizable PRR model in GLB system benches and as the PRR I/O shell.

---
 rtl/cgra_io_stream_responder_if.sv | 34 +++
 rtl/cgra_io_stream_responder.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cgra_io_stream_responder_if.sv
// Stream and config bundle between the GLB tile and one PRR column.
// The responder uses the slave modport; the GLB side (or a bench) drives the master view.
interface cgra_io_stream_responder_if #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned CFG_ADDR_WIDTH = 32,
    parameter int unsigned CFG_DATA_WIDTH = 32
);
    logic                      cfg_wr_en;
    logic [CFG_ADDR_WIDTH-1:0] cfg_wr_addr;
    logic [CFG_DATA_WIDTH-1:0] cfg_wr_data;
    logic                      cfg_rd_en;
    logic [CFG_ADDR_WIDTH-1:0] cfg_rd_addr;
    logic [CFG_DATA_WIDTH-1:0] cfg_rd_data;
    logic                      io1_g2io;
    logic [DATA_WIDTH-1:0]     io16_g2io;
    logic                      io16_g2io_vld;
    logic                      io16_g2io_rdy;
    logic                      io1_io2g;
    logic [DATA_WIDTH-1:0]     io16_io2g;
    logic                      io16_io2g_vld;
    logic                      io16_io2g_rdy;

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_en, cfg_rd_addr,
        input  io1_g2io, io16_g2io, io16_g2io_vld, io16_io2g_rdy,
        output cfg_rd_data, io16_g2io_rdy, io1_io2g, io16_io2g, io16_io2g_vld
    );

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_rd_en, cfg_rd_addr,
        output io1_g2io, io16_g2io, io16_g2io_vld, io16_io2g_rdy,
        input  cfg_rd_data, io16_g2io_rdy, io1_io2g, io16_io2g, io16_io2g_vld
    );
endinterface

// File: rtl/cgra_io_stream_responder.sv
// PRR-side stream endpoint: config register file plus a g2f->f2g FIFO that adds an
// optional offset to each word and counts words returned to the GLB.
module cgra_io_stream_responder #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned CFG_ADDR_WIDTH = 32,
    parameter int unsigned CFG_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input logic                        clk,
    input logic                        reset,
    input logic                        stall,
    cgra_io_stream_responder_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic                      r_en;
    logic                      r_bypass;
    logic [DATA_WIDTH-1:0]     r_offset;
    logic [CFG_DATA_WIDTH-1:0] r_count;
    logic [CFG_DATA_WIDTH-1:0] r_cfg_rd_data;
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [PTR_W:0]            r_level;
    logic [DATA_WIDTH-1:0]     r_mem_data [FIFO_DEPTH];
    logic                      r_mem_ctrl [FIFO_DEPTH];

    logic                      w_full;
    logic                      w_empty;
    logic                      w_rdy;
    logic                      w_vld;
    logic                      w_push;
    logic                      w_pop;
    logic [DATA_WIDTH-1:0]     w_push_data;
    logic [CFG_DATA_WIDTH-1:0] w_status;
    logic [CFG_DATA_WIDTH-1:0] w_rd_mux;
    logic                      w_wr_count;
    logic                      w_unused;

    assign w_full      = (r_level == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_rdy       = r_en & ~stall & ~w_full;
    assign w_vld       = ~w_empty & ~stall;
    assign w_push      = w_rdy & bus.io16_g2io_vld;
    assign w_pop       = w_vld & bus.io16_io2g_rdy;
    assign w_push_data = r_bypass ? bus.io16_g2io : bus.io16_g2io + r_offset;
    assign w_wr_count  = bus.cfg_wr_en & (bus.cfg_wr_addr[1:0] == 2'd2);

    assign bus.io16_g2io_rdy = w_rdy;
    assign bus.io16_io2g_vld = w_vld;
    assign bus.io16_io2g     = r_mem_data[r_rd_ptr];
    assign bus.io1_io2g      = r_mem_ctrl[r_rd_ptr] & w_vld;
    assign bus.cfg_rd_data   = r_cfg_rd_data;

    assign w_unused = ^{bus.cfg_wr_addr[CFG_ADDR_WIDTH-1:2], bus.cfg_rd_addr[CFG_ADDR_WIDTH-1:2],
                        bus.cfg_wr_data[CFG_DATA_WIDTH-1:DATA_WIDTH]};

    always_comb begin
        w_status            = '0;
        w_status[PTR_W:0]   = r_level;
        w_status[8]         = w_full;
        w_status[9]         = w_empty;
    end

    always_comb begin
        w_rd_mux = '0;
        case (bus.cfg_rd_addr[1:0])
            2'd0:    w_rd_mux[1:0] = {r_bypass, r_en};
            2'd1:    w_rd_mux[DATA_WIDTH-1:0] = r_offset;
            2'd2:    w_rd_mux = r_count;
            default: w_rd_mux = w_status;
        endcase
    end

    // Memory is cleared too so the f2g data bus reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem_data[i] <= '0;
                r_mem_ctrl[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_push_data;
                r_mem_ctrl[r_wr_ptr] <= bus.io1_g2io;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Reads sample pre-write state, so a same-address write is not visible yet.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en          <= 1'b0;
            r_bypass      <= 1'b0;
            r_offset      <= '0;
            r_count       <= '0;
            r_cfg_rd_data <= '0;
        end else begin
            if (bus.cfg_wr_en && bus.cfg_wr_addr[1:0] == 2'd0) begin
                r_en     <= bus.cfg_wr_data[0];
                r_bypass <= bus.cfg_wr_data[1];
            end
            if (bus.cfg_wr_en && bus.cfg_wr_addr[1:0] == 2'd1) begin
                r_offset <= bus.cfg_wr_data[DATA_WIDTH-1:0];
            end
            if (w_wr_count) begin
                r_count <= '0;
            end else if (w_pop) begin
                r_count <= r_count + 1'b1;
            end
            if (bus.cfg_rd_en) begin
                r_cfg_rd_data <= w_rd_mux;
            end
        end
    end
endmodule
